uart_tx_port: RTL and testbench

//  Memory-mapped 8N1 UART transmitter on the shared CPU word bus, beside the block RAM.

---
 rtl/uart_tx_port.sv | 217 +++++++++++++++++++++
 tb/tb_uart_tx_port.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_port.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_port
// Purpose  : Memory-mapped 8N1 UART transmitter with a TX FIFO. It sits on the
//            CPU word bus, and its registered read data is ORed with the RAM's.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_port #(
    parameter logic [29:0] BASE_ADDR  = 30'h0000_0400,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [29:0] bus_addr,
    input  logic [31:0] bus_data_w,
    input  logic [3:0]  bus_mask_w,
    output logic [31:0] bus_data_r,
    output logic        tx,
    output logic        irq
);
    localparam int            AW      = $clog2(FIFO_DEPTH);
    localparam int            CW      = AW + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic [15:0]   r_div;
    logic          r_irq_en;
    logic [7:0]    r_shreg, w_shreg_nxt;
    logic [2:0]    r_bit_idx, w_bit_idx_nxt;
    logic [15:0]   r_baud_cnt, w_baud_cnt_nxt;
    logic          r_tx, w_tx_nxt;
    logic [31:0]   r_rdata, w_rd_val;

    logic          w_hit, w_full, w_empty, w_busy;
    logic          w_push_req, w_push, w_pop, w_bit_end;
    logic [1:0]    w_reg;
    logic [15:0]   w_bit_time;
    logic [3:0]    w_cnt_sat;
    logic          w_unused;

    assign w_hit      = (bus_addr[29:2] == BASE_ADDR[29:2]);
    assign w_reg      = bus_addr[1:0];
    assign w_full     = (r_count == C_DEPTH);
    assign w_empty    = (r_count == '0);
    assign w_busy     = (r_state != S_IDLE);
    assign w_push_req = w_hit && (w_reg == 2'd0) && bus_mask_w[0];
    assign w_push     = w_push_req && !w_full;
    assign w_bit_time = (r_div == 16'd0) ? 16'd1 : r_div;
    assign w_bit_end  = (r_baud_cnt == 16'd0);
    assign w_unused   = ^{bus_data_w[31:16], bus_mask_w[3:2]};

    generate
        if (CW > 4) begin : g_cnt_sat_wide
            assign w_cnt_sat = (r_count > CW'(15)) ? 4'hF : r_count[3:0];
        end else begin : g_cnt_sat_narrow
            assign w_cnt_sat = 4'(r_count);
        end
    endgenerate

    // Transmit sequencer; a frame ending with data still queued starts the
    // next one on the same edge so back-to-back bytes take 10 bit times.
    always_comb begin
        w_state_nxt    = r_state;
        w_pop          = 1'b0;
        w_tx_nxt       = r_tx;
        w_shreg_nxt    = r_shreg;
        w_bit_idx_nxt  = r_bit_idx;
        w_baud_cnt_nxt = w_bit_end ? r_baud_cnt : r_baud_cnt - 16'd1;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop          = 1'b1;
                    w_shreg_nxt    = r_mem[r_rd_ptr];
                    w_tx_nxt       = 1'b0;
                    w_baud_cnt_nxt = w_bit_time - 16'd1;
                    w_state_nxt    = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt    = S_DATA;
                    w_bit_idx_nxt  = 3'd0;
                    w_tx_nxt       = r_shreg[0];
                    w_baud_cnt_nxt = w_bit_time - 16'd1;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_baud_cnt_nxt = w_bit_time - 16'd1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                        w_shreg_nxt   = {1'b0, r_shreg[7:1]};
                        w_tx_nxt      = r_shreg[1];
                    end
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    if (!w_empty) begin
                        w_pop          = 1'b1;
                        w_shreg_nxt    = r_mem[r_rd_ptr];
                        w_tx_nxt       = 1'b0;
                        w_baud_cnt_nxt = w_bit_time - 16'd1;
                        w_state_nxt    = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_tx_nxt    = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_tx       <= 1'b1;
            r_shreg    <= 8'h00;
            r_bit_idx  <= 3'd0;
            r_baud_cnt <= 16'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_tx       <= w_tx_nxt;
            r_shreg    <= w_shreg_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_baud_cnt <= w_baud_cnt_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus_data_w[7:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_push_req && w_full) begin
                r_ovf <= 1'b1;
            end else if (w_hit && (w_reg == 2'd1) && bus_mask_w[0] && bus_data_w[3]) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_div    <= DIV_RESET;
            r_irq_en <= 1'b0;
        end else if (w_hit) begin
            if (w_reg == 2'd2) begin
                if (bus_mask_w[0]) r_div[7:0]  <= bus_data_w[7:0];
                if (bus_mask_w[1]) r_div[15:8] <= bus_data_w[15:8];
            end
            if ((w_reg == 2'd3) && bus_mask_w[0]) begin
                r_irq_en <= bus_data_w[0];
            end
        end
    end

    // Read data reflects register state before any write on the same edge.
    always_comb begin
        w_rd_val = 32'h0;
        case (w_reg)
            2'd1:    w_rd_val[7:0]  = {w_cnt_sat, r_ovf, w_busy, w_empty, w_full};
            2'd2:    w_rd_val[15:0] = r_div;
            2'd3:    w_rd_val[0]    = r_irq_en;
            default: w_rd_val       = 32'h0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rdata <= 32'h0;
        end else begin
            r_rdata <= w_hit ? w_rd_val : 32'h0;
        end
    end

    assign bus_data_r = r_rdata;
    assign tx         = r_tx;
    assign irq        = r_irq_en && w_empty && !w_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_port
// Purpose  : Self-checking bench for uart_tx_port: directed scenarios plus
//            random bus traffic scored against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_port;
    localparam logic [29:0] C_BASE    = 30'h0000_0400;
    localparam int          C_DEPTH   = 8;
    localparam logic [15:0] C_DIV_RST = 16'd16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [29:0] bus_addr = 30'h0;
    logic [31:0] bus_data_w = 32'h0;
    logic [3:0]  bus_mask_w = 4'h0;
    logic [31:0] bus_data_r;
    logic        tx;
    logic        irq;

    uart_tx_port #(
        .BASE_ADDR (C_BASE),
        .FIFO_DEPTH(C_DEPTH),
        .DIV_RESET (C_DIV_RST)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .bus_addr  (bus_addr),
        .bus_data_w(bus_data_w),
        .bus_mask_w(bus_mask_w),
        .bus_data_r(bus_data_r),
        .tx        (tx),
        .irq       (irq)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a byte queue plus the start/end edge of the frame in flight.
    byte unsigned m_q[$];
    bit          m_active = 1'b0;
    bit          m_ovf = 1'b0;
    bit          m_en = 1'b0;
    logic [15:0] m_div = C_DIV_RST;
    logic [7:0]  m_cur = 8'h0;
    longint      m_edge = 0;
    longint      m_start = 0;
    longint      m_end = 0;
    int          m_bt = 1;
    logic [31:0] exp_rd = 32'h0;
    logic        exp_tx = 1'b1;
    logic        exp_irq = 1'b0;
    bit          mon_en = 1'b0;

    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i >= 9) return 1'b1;
        return b[i-1];
    endfunction

    always @(posedge clock) begin : p_model
        int       sz;
        bit       hit;
        bit       pop;
        logic [3:0] cs;
        hit = (bus_addr[29:2] == C_BASE[29:2]);
        sz  = m_q.size();
        if (reset) begin
            m_q.delete();
            m_active = 1'b0;
            m_ovf    = 1'b0;
            m_en     = 1'b0;
            m_div    = C_DIV_RST;
            exp_rd   = 32'h0;
        end else begin
            cs     = (sz > 15) ? 4'hF : 4'(sz);
            exp_rd = 32'h0;
            if (hit) begin
                case (bus_addr[1:0])
                    2'd1:    exp_rd = {24'h0, cs, m_ovf, m_active, (sz == 0), (sz == C_DEPTH)};
                    2'd2:    exp_rd = {16'h0, m_div};
                    2'd3:    exp_rd = {31'h0, m_en};
                    default: exp_rd = 32'h0;
                endcase
            end
            pop = (sz > 0) && (!m_active || (m_edge == m_end));
            if (m_active && (m_edge == m_end) && !pop) m_active = 1'b0;
            if (pop) begin
                m_cur    = m_q.pop_front();
                m_active = 1'b1;
                m_start  = m_edge;
                m_bt     = (m_div == 16'd0) ? 1 : int'(m_div);
                m_end    = m_edge + 10 * m_bt;
            end
            if (hit) begin
                case (bus_addr[1:0])
                    2'd0: begin
                        if (bus_mask_w[0]) begin
                            if (sz < C_DEPTH) m_q.push_back(bus_data_w[7:0]);
                            else m_ovf = 1'b1;
                        end
                    end
                    2'd1: if (bus_mask_w[0] && bus_data_w[3]) m_ovf = 1'b0;
                    2'd2: begin
                        if (bus_mask_w[0]) m_div[7:0]  = bus_data_w[7:0];
                        if (bus_mask_w[1]) m_div[15:8] = bus_data_w[15:8];
                    end
                    default: if (bus_mask_w[0]) m_en = bus_data_w[0];
                endcase
            end
        end
        exp_tx  = m_active ? frame_bit(m_cur, int'((m_edge - m_start) / m_bt)) : 1'b1;
        exp_irq = m_en && (m_q.size() == 0) && !m_active;
        m_edge++;
    end

    always @(negedge clock) begin
        if (mon_en) begin
            check_val("mon_tx", 32'(tx), 32'(exp_tx));
            check_val("mon_rd", bus_data_r, exp_rd);
            check_val("mon_irq", 32'(irq), 32'(exp_irq));
        end
    end

    task automatic bus_access(input logic [29:0] a, input logic [31:0] d,
                              input logic [3:0] m, output logic [31:0] rd);
        bus_addr   = a;
        bus_data_w = d;
        bus_mask_w = m;
        @(posedge clock);
        @(negedge clock);
        bus_mask_w = 4'h0;
        rd         = bus_data_r;
    endtask

    initial begin : p_watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : p_stim
        logic [31:0] v;
        logic [9:0]  fr;
        bit          done;
        int          op;

        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 mon_en = 1'b1;
        @(negedge clock);
        reset = 1'b0;

        check_val("rst_tx", 32'(tx), 32'd1);
        check_val("rst_irq", 32'(irq), 32'd0);
        bus_access(C_BASE + 30'd1, 32'h0, 4'h0, v);
        check_val("rst_status", v, 32'h0000_0002);
        bus_access(C_BASE + 30'd2, 32'h0, 4'h0, v);
        check_val("rst_div", v, 32'd16);
        bus_access(C_BASE + 30'd3, 32'h0, 4'h0, v);
        check_val("rst_ctrl", v, 32'd0);
        bus_access(30'h0000_0001, 32'h0, 4'h0, v);
        check_val("nohit_rd", v, 32'd0);

        // 8'hA5 at 4 clocks per bit
        bus_access(C_BASE + 30'd2, 32'd4, 4'b0011, v);
        bus_access(C_BASE, 32'h0000_00A5, 4'b0001, v);
        fr = {1'b1, 8'hA5, 1'b0};
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            check_val("a5_line", 32'(tx), 32'(fr[k/4]));
        end
        bus_access(C_BASE + 30'd1, 32'h0, 4'h0, v);
        check_val("a5_busy_last", v, 32'h6);
        bus_access(C_BASE + 30'd1, 32'h0, 4'h0, v);
        check_val("a5_idle", v, 32'h2);

        // Independent DIVISOR lanes
        bus_access(C_BASE + 30'd2, 32'h1234_AB07, 4'b0010, v);
        bus_access(C_BASE + 30'd2, 32'h0, 4'h0, v);
        check_val("div_lane1", v, 32'h0000_AB04);
        bus_access(C_BASE + 30'd2, 32'h0000_0002, 4'b0001, v);
        bus_access(C_BASE + 30'd2, 32'h0, 4'h0, v);
        check_val("div_lane0", v, 32'h0000_AB02);
        bus_access(C_BASE + 30'd2, 32'hFFFF_0002, 4'b1111, v);
        bus_access(C_BASE + 30'd2, 32'h0, 4'h0, v);
        check_val("div_full", v, 32'h0000_0002);

        // Burst beyond FIFO capacity
        for (int i = 0; i < 10; i++) bus_access(C_BASE, 32'($urandom), 4'b0001, v);
        bus_access(C_BASE + 30'd1, 32'h0, 4'h0, v);
        check_val("ovf_status", v, 32'h8D);
        for (int i = 0; i < 25; i++) bus_access(C_BASE, 32'($urandom), 4'b0001, v);
        bus_access(C_BASE + 30'd1, 32'h0, 4'h0, v);
        check_val("full_again", v, 32'h8D);
        bus_access(C_BASE + 30'd1, 32'h0000_0008, 4'b0001, v);
        bus_access(C_BASE + 30'd1, 32'h0, 4'h0, v);
        check_val("ovf_clear", v, 32'h85);

        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            bus_access(C_BASE + 30'd1, 32'h0, 4'h0, v);
            if (v == 32'h2) done = 1'b1;
        end
        check_val("drain", 32'(done), 32'd1);

        // Interrupt timing at 1 clock per bit
        bus_access(C_BASE + 30'd3, 32'd1, 4'b0001, v);
        check_val("irq_idle", 32'(irq), 32'd1);
        bus_access(C_BASE + 30'd2, 32'd1, 4'b0011, v);
        bus_access(C_BASE, 32'h0000_003C, 4'b0001, v);
        check_val("irq_queued", 32'(irq), 32'd0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            check_val("irq_busy", 32'(irq), 32'd0);
        end
        @(negedge clock);
        check_val("irq_after_stop", 32'(irq), 32'd1);

        // Reset during data bit 3 with bytes still queued
        bus_access(C_BASE + 30'd2, 32'd4, 4'b0011, v);
        for (int i = 0; i < 3; i++) bus_access(C_BASE, 32'($urandom), 4'b0001, v);
        repeat (16) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check_val("rst_mid_tx", 32'(tx), 32'd1);
        for (int k = 0; k < 60; k++) begin
            @(negedge clock);
            check_val("quiet_line", 32'(tx), 32'd1);
        end
        bus_access(C_BASE + 30'd1, 32'h0, 4'h0, v);
        check_val("rst_mid_status", v, 32'h2);
        bus_access(C_BASE + 30'd4, 32'h0, 4'h0, v);
        check_val("nohit_next", v, 32'd0);

        // Random bus traffic scored by the model
        for (int c = 0; c < 4000; c++) begin
            op = $urandom_range(0, 99);
            if (op < 40) begin
                bus_access(bus_addr, 32'h0, 4'h0, v);
            end else if (op < 60) begin
                bus_access(C_BASE + 30'($urandom_range(0, 3)), 32'h0, 4'h0, v);
            end else if (op < 80) begin
                bus_access(C_BASE, 32'($urandom), 4'($urandom_range(0, 15)), v);
            end else if (op < 85) begin
                bus_access(C_BASE + 30'd1, 32'($urandom), 4'($urandom_range(0, 15)), v);
            end else if (op < 90) begin
                bus_access(C_BASE + 30'd3, 32'($urandom), 4'($urandom_range(0, 15)), v);
            end else if (op < 95) begin
                if (!m_active && (m_q.size() == 0))
                    bus_access(C_BASE + 30'd2, 32'($urandom_range(0, 3)), 4'b0011, v);
                else
                    bus_access(bus_addr, 32'h0, 4'h0, v);
            end else begin
                bus_access(C_BASE + 30'(4 + $urandom_range(0, 1023)), 32'($urandom),
                           4'($urandom_range(0, 15)), v);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
